// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter
// Arbitrates one physical memory port between L2 line fills and
// eviction write buffer (EWB) drains. A five-state FSM sequences each
// transaction. Every output comes from a register or is decoded from
// the state register, so no input reaches an output combinationally.
//
// Parameters:
//   WIDTH      - cacheline width in bits
//   STARVE_MAX - consecutive read grants allowed while the EWB holds
//                entries (only meaningful with EWB_STARVE_GUARD_EN)
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   l2_read_i / l2_addr_i    - L2 fill request and line address
//   l2_rdata_o / l2_resp_o   - fill data and one-cycle completion pulse
//   ewb_empty_i, ewb_full_i  - EWB occupancy status
//   ewb_data_i, ewb_addr_i   - EWB head entry
//   ewb_yumi_o               - one-cycle dequeue strobe to the EWB
//   pmem_read_o/pmem_write_o - memory strobes, held until pmem_resp_i
//   pmem_addr_o/pmem_wdata_o - latched transaction address and data
//   pmem_rdata_i/pmem_resp_i - memory read data and completion
//
// Configuration macro:
//   EWB_STARVE_GUARD_EN - when defined, a saturating counter forces an
//                         EWB drain after STARVE_MAX reads granted while
//                         the EWB is non-empty. Undefined: reads always
//                         win unless the EWB is full.

module l2_mem_arbiter #(
    parameter int WIDTH      = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             l2_read_i,
    input  logic [31:0]      l2_addr_i,
    output logic [WIDTH-1:0] l2_rdata_o,
    output logic             l2_resp_o,
    input  logic             ewb_empty_i,
    input  logic             ewb_full_i,
    input  logic [WIDTH-1:0] ewb_data_i,
    input  logic [31:0]      ewb_addr_i,
    output logic             ewb_yumi_o,
    output logic             pmem_read_o,
    output logic             pmem_write_o,
    output logic [31:0]      pmem_addr_o,
    output logic [WIDTH-1:0] pmem_wdata_o,
    input  logic [WIDTH-1:0] pmem_rdata_i,
    input  logic             pmem_resp_i
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RESP,
        WRITE,
        WACK
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              starved;

`ifdef EWB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              grant_read;
    logic              grant_write;

    assign starved     = (starve_cnt_q == CNT_W'(STARVE_MAX));
    assign grant_read  = (state_q == IDLE) && (state_d == READ);
    assign grant_write = (state_q == IDLE) && (state_d == WRITE);

    // Empty EWB or a drain resets the count; saturate at STARVE_MAX.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ewb_empty_i || grant_write) begin
            starve_cnt_d = '0;
        end else if (grant_read && !starved) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Guard disabled: parameter retained so both builds share one interface.
    localparam int starve_max_unused = STARVE_MAX;

    assign starved = 1'b0;
`endif

    // Next-state logic; address/data latch on entry to READ/WRITE and
    // fill data is captured on the memory response.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (ewb_full_i || (starved && !ewb_empty_i)) begin
                    state_d = WRITE;
                    addr_d  = ewb_addr_i;
                    wdata_d = ewb_data_i;
                end else if (l2_read_i) begin
                    state_d = READ;
                    addr_d  = l2_addr_i;
                end else if (!ewb_empty_i) begin
                    state_d = WRITE;
                    addr_d  = ewb_addr_i;
                    wdata_d = ewb_data_i;
                end
            end
            READ: begin
                if (pmem_resp_i) begin
                    state_d = RESP;
                    rdata_d = pmem_rdata_i;
                end
            end
            RESP:    state_d = IDLE;
            WRITE: begin
                if (pmem_resp_i) begin
                    state_d = WACK;
                end
            end
            WACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes are pure state decodes, so read/write can never overlap.
    assign pmem_read_o  = (state_q == READ);
    assign pmem_write_o = (state_q == WRITE);
    assign l2_resp_o    = (state_q == RESP);
    assign ewb_yumi_o   = (state_q == WACK);
    assign pmem_addr_o  = addr_q;
    assign pmem_wdata_o = wdata_q;
    assign l2_rdata_o   = rdata_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter
// Directed self-checking bench for l2_mem_arbiter. Inputs are driven
// and outputs sampled on the falling clock edge; the DUT acts on the
// rising edge in between.

module tb_l2_mem_arbiter;

    localparam int W = 256;

    logic          clk;
    logic          rst;
    logic          l2_read_i;
    logic [31:0]   l2_addr_i;
    logic [W-1:0]  l2_rdata_o;
    logic          l2_resp_o;
    logic          ewb_empty_i;
    logic          ewb_full_i;
    logic [W-1:0]  ewb_data_i;
    logic [31:0]   ewb_addr_i;
    logic          ewb_yumi_o;
    logic          pmem_read_o;
    logic          pmem_write_o;
    logic [31:0]   pmem_addr_o;
    logic [W-1:0]  pmem_wdata_o;
    logic [W-1:0]  pmem_rdata_i;
    logic          pmem_resp_i;

    int num_checks;
    int num_errors;

    l2_mem_arbiter #(.WIDTH(W), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .l2_read_i    (l2_read_i),
        .l2_addr_i    (l2_addr_i),
        .l2_rdata_o   (l2_rdata_o),
        .l2_resp_o    (l2_resp_o),
        .ewb_empty_i  (ewb_empty_i),
        .ewb_full_i   (ewb_full_i),
        .ewb_data_i   (ewb_data_i),
        .ewb_addr_i   (ewb_addr_i),
        .ewb_yumi_o   (ewb_yumi_o),
        .pmem_read_o  (pmem_read_o),
        .pmem_write_o (pmem_write_o),
        .pmem_addr_o  (pmem_addr_o),
        .pmem_wdata_o (pmem_wdata_o),
        .pmem_rdata_i (pmem_rdata_i),
        .pmem_resp_i  (pmem_resp_i)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the requester-side inputs.
    task automatic applyStimulus(input logic rd, input logic [31:0] raddr,
                                 input logic empty, input logic full,
                                 input logic [31:0] waddr, input logic [W-1:0] wdata);
        l2_read_i   = rd;
        l2_addr_i   = raddr;
        ewb_empty_i = empty;
        ewb_full_i  = full;
        ewb_addr_i  = waddr;
        ewb_data_i  = wdata;
    endtask

    // Strobe vector order: {pmem_read, pmem_write, l2_resp, ewb_yumi}.
    function automatic logic [W-1:0] strobes();
        return W'({pmem_read_o, pmem_write_o, l2_resp_o, ewb_yumi_o});
    endfunction

    logic [W-1:0] data_a5;
    logic [W-1:0] data_1234;
    logic [W-1:0] data_other;
    logic         exp_write;

    initial begin
        num_checks   = 0;
        num_errors   = 0;
        data_a5      = {32{8'hA5}};
        data_1234    = {8{32'h1234_5678}};
        data_other   = {8{32'hDEAD_BEEF}};
        rst          = 1'b1;
        pmem_resp_i  = 1'b0;
        pmem_rdata_i = '0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_strobes", strobes(), W'(4'b0000));
        checkOutput("rst_addr", W'(pmem_addr_o), W'(32'h0));
        checkOutput("rst_wdata", pmem_wdata_o, '0);
        checkOutput("rst_rdata", l2_rdata_o, '0);
        rst = 1'b0;

        // Read only, memory answers in the third READ cycle.
        applyStimulus(1'b1, 32'h0000_1240, 1'b1, 1'b0, 32'h0, '0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rd_strobe_c%0d", i), strobes(), W'(4'b1000));
            checkOutput($sformatf("rd_addr_c%0d", i), W'(pmem_addr_o), W'(32'h0000_1240));
            if (i == 3) begin
                pmem_resp_i  = 1'b1;
                pmem_rdata_i = data_a5;
            end
        end
        @(negedge clk);
        pmem_resp_i = 1'b0;
        l2_read_i   = 1'b0;
        checkOutput("rd_resp", strobes(), W'(4'b0010));
        checkOutput("rd_data", l2_rdata_o, data_a5);
        @(negedge clk);
        checkOutput("rd_resp_one_cycle", strobes(), W'(4'b0000));
        checkOutput("rd_data_hold", l2_rdata_o, data_a5);

        // Drain while idle.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_8000, data_1234);
        @(negedge clk);
        checkOutput("dr_strobe", strobes(), W'(4'b0100));
        checkOutput("dr_addr", W'(pmem_addr_o), W'(32'h0000_8000));
        checkOutput("dr_wdata", pmem_wdata_o, data_1234);
        pmem_resp_i = 1'b1;
        @(negedge clk);
        pmem_resp_i = 1'b0;
        ewb_empty_i = 1'b1;
        checkOutput("dr_yumi", strobes(), W'(4'b0001));
        @(negedge clk);
        checkOutput("dr_yumi_one_cycle", strobes(), W'(4'b0000));

        // Read and non-full EWB together: read wins, write follows.
        applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0000_9000, data_1234);
        @(negedge clk);
        checkOutput("sim_read_first", strobes(), W'(4'b1000));
        checkOutput("sim_read_addr", W'(pmem_addr_o), W'(32'h0000_2000));
        pmem_resp_i  = 1'b1;
        pmem_rdata_i = data_other;
        @(negedge clk);
        pmem_resp_i = 1'b0;
        l2_read_i   = 1'b0;
        checkOutput("sim_resp", strobes(), W'(4'b0010));
        checkOutput("sim_rdata", l2_rdata_o, data_other);
        @(negedge clk);
        checkOutput("sim_gap", strobes(), W'(4'b0000));
        @(negedge clk);
        checkOutput("sim_write_next", strobes(), W'(4'b0100));
        checkOutput("sim_write_addr", W'(pmem_addr_o), W'(32'h0000_9000));
        pmem_resp_i = 1'b1;
        @(negedge clk);
        pmem_resp_i = 1'b0;
        ewb_empty_i = 1'b1;
        checkOutput("sim_yumi", strobes(), W'(4'b0001));
        @(negedge clk);

        // Full EWB overrides a pending read.
        applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b1, 32'h0000_A000, data_other);
        @(negedge clk);
        checkOutput("full_write_first", strobes(), W'(4'b0100));
        checkOutput("full_write_addr", W'(pmem_addr_o), W'(32'h0000_A000));
        checkOutput("full_write_data", pmem_wdata_o, data_other);
        pmem_resp_i = 1'b1;
        @(negedge clk);
        pmem_resp_i = 1'b0;
        ewb_full_i  = 1'b0;
        ewb_empty_i = 1'b1;
        checkOutput("full_yumi", strobes(), W'(4'b0001));
        @(negedge clk);
        checkOutput("full_gap", strobes(), W'(4'b0000));
        @(negedge clk);
        checkOutput("full_read_next", strobes(), W'(4'b1000));
        checkOutput("full_read_addr", W'(pmem_addr_o), W'(32'h0000_3000));
        pmem_resp_i  = 1'b1;
        pmem_rdata_i = data_1234;
        @(negedge clk);
        pmem_resp_i = 1'b0;
        l2_read_i   = 1'b0;
        checkOutput("full_resp", strobes(), W'(4'b0010));
        checkOutput("full_rdata", l2_rdata_o, data_1234);
        @(negedge clk);

        // Continuous reads with a non-empty EWB.
        applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b0, 32'h0000_B000, data_a5);
        for (int g = 0; g < 5; g++) begin
`ifdef EWB_STARVE_GUARD_EN
            exp_write = (g == 4);
`else
            exp_write = 1'b0;
`endif
            @(negedge clk);
            checkOutput($sformatf("stv_grant%0d", g), strobes(),
                        exp_write ? W'(4'b0100) : W'(4'b1000));
            pmem_resp_i  = 1'b1;
            pmem_rdata_i = W'(g + 7);
            @(negedge clk);
            pmem_resp_i = 1'b0;
            checkOutput($sformatf("stv_done%0d", g), strobes(),
                        exp_write ? W'(4'b0001) : W'(4'b0010));
            @(negedge clk);
            checkOutput($sformatf("stv_gap%0d", g), strobes(), W'(4'b0000));
            if (g == 4) begin
                applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, '0);
            end
        end
        @(negedge clk);

        // Memory response while idle is ignored.
        pmem_resp_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pmem_resp_i = 1'b0;
        checkOutput("idle_resp_ignored", strobes(), W'(4'b0000));

        // Reset two cycles into a WRITE abandons it.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_C000, data_a5);
        @(negedge clk);
        checkOutput("rstw_write_c1", strobes(), W'(4'b0100));
        @(negedge clk);
        checkOutput("rstw_write_c2", strobes(), W'(4'b0100));
        rst         = 1'b1;
        pmem_resp_i = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        pmem_resp_i = 1'b0;
        ewb_empty_i = 1'b1;
        checkOutput("rstw_strobes", strobes(), W'(4'b0000));
        checkOutput("rstw_addr", W'(pmem_addr_o), W'(32'h0));
        checkOutput("rstw_wdata", pmem_wdata_o, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rstw_no_yumi%0d", i), strobes(), W'(4'b0000));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_errors);
        $finish;
    end

endmodule
